// File: rtl/pipe_exe_md_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit.
package pipe_exe_md_pkg;

    localparam int unsigned DEF_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // LO value left by a divide with a zero divisor
    localparam logic [DEF_WIDTH-1:0] DIV0_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/pipe_exe_md_div_core.sv
// Iterative restoring unsigned divider: one quotient bit per step, WIDTH steps.
module pipe_exe_md_div_core
    import pipe_exe_md_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quot_nxt_c,
    output logic [WIDTH-1:0] rem_nxt_c,
    output logic             done_c
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] divisor_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   diff;

    // Trial subtraction; the remainder stays below the divisor, so diff[WIDTH] is a clean borrow
    always_comb begin
        rem_shift  = {rem_q, quot_q[WIDTH-1]};
        diff       = rem_shift - {1'b0, divisor_q};
        rem_nxt_c  = diff[WIDTH-1:0];
        quot_nxt_c = {quot_q[WIDTH-2:0], 1'b1};
        if (diff[WIDTH]) begin
            rem_nxt_c  = rem_shift[WIDTH-1:0];
            quot_nxt_c = {quot_q[WIDTH-2:0], 1'b0};
        end
    end

    assign done_c = step && (count_q == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            quot_q    <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
            count_q   <= '0;
        end else if (start) begin
            quot_q    <= dividend;
            rem_q     <= '0;
            divisor_q <= divisor;
            count_q   <= '0;
        end else if (step) begin
            quot_q    <= quot_nxt_c;
            rem_q     <= rem_nxt_c;
            count_q   <= count_q + CW'(1);
        end
    end

endmodule

// File: rtl/pipe_exe_md.sv
// Execute-stage multiply/divide unit with HI/LO registers and upstream stall.
module pipe_exe_md
    import pipe_exe_md_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mult,
    input  logic             multu,
    input  logic             div,
    input  logic             divu,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic             mfhi,
    input  logic             mflo,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic [WIDTH-1:0] hilo_rdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_e           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_signed;
    logic [WIDTH-1:0] a_orig;
    logic             div_by_zero;
    logic             neg_q;
    logic             neg_r;

    logic             mul_req;
    logic             div_req;
    logic             accept_div;
    logic             div_step;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [2*WIDTH-1:0] ext_a;
    logic [2*WIDTH-1:0] ext_b;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0] quot_nxt;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;
    logic             div_done;

    assign mul_req    = mult | multu;
    assign div_req    = div | divu;
    assign accept_div = (state == ST_IDLE) && div_req && !flush;
    assign div_step   = (state == ST_DIV) && !flush;

    // Stall covers the accept cycle and the whole operation; a flush releases it immediately
    assign stall = !flush && (((state == ST_IDLE) && (mul_req || div_req)) ||
                              (state == ST_MUL) || (state == ST_DIV));
    assign busy       = (state != ST_IDLE);
    assign hilo_rdata = mfhi ? hi : lo;

    // Signed divide works on magnitudes; signs are restored on the final step
    assign a_mag = (div && a[WIDTH-1]) ? -a : a;
    assign b_mag = (div && b[WIDTH-1]) ? -b : b;

    always_comb begin
        ext_a   = op_signed ? {{WIDTH{op_a[WIDTH-1]}}, op_a} : {{WIDTH{1'b0}}, op_a};
        ext_b   = op_signed ? {{WIDTH{op_b[WIDTH-1]}}, op_b} : {{WIDTH{1'b0}}, op_b};
        product = ext_a * ext_b;
    end

    assign quot_fix = neg_q ? -quot_nxt : quot_nxt;
    assign rem_fix  = neg_r ? -rem_nxt : rem_nxt;

    pipe_exe_md_div_core #(
        .WIDTH      (WIDTH)
    ) u_div_core (
        .clk        (clk),
        .rst        (rst),
        .start      (accept_div),
        .step       (div_step),
        .dividend   (a_mag),
        .divisor    (b_mag),
        .quot_nxt_c (quot_nxt),
        .rem_nxt_c  (rem_nxt),
        .done_c     (div_done)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_IDLE;
            hi          <= '0;
            lo          <= '0;
            op_a        <= '0;
            op_b        <= '0;
            op_signed   <= 1'b0;
            a_orig      <= '0;
            div_by_zero <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!flush) begin
                        if (mul_req) begin
                            op_a      <= a;
                            op_b      <= b;
                            op_signed <= mult;
                            state     <= ST_MUL;
                        end else if (div_req) begin
                            a_orig      <= a;
                            div_by_zero <= (b == '0);
                            neg_q       <= div && (a[WIDTH-1] ^ b[WIDTH-1]);
                            neg_r       <= div && a[WIDTH-1];
                            state       <= ST_DIV;
                        end else if (mthi) begin
                            hi <= a;
                        end else if (mtlo) begin
                            lo <= a;
                        end
                    end
                end
                ST_MUL: begin
                    if (flush) begin
                        state <= ST_IDLE;
                    end else begin
                        {hi, lo} <= product;
                        state    <= ST_DONE;
                    end
                end
                ST_DIV: begin
                    if (flush) begin
                        state <= ST_IDLE;
                    end else if (div_done) begin
                        // A zero divisor bypasses the sign fixup entirely
                        if (div_by_zero) begin
                            lo <= WIDTH'(DIV0_LO);
                            hi <= a_orig;
                        end else begin
                            lo <= quot_fix;
                            hi <= rem_fix;
                        end
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Decode never issues more than one control strobe per instruction
    always_ff @(posedge clk) begin
        if (rst) begin
            assert ($onehot0({mult, multu, div, divu, mthi, mtlo, mfhi, mflo}));
        end
    end

endmodule

// File: tb/tb_pipe_exe_md.sv
// Directed and randomized checks of pipe_exe_md against an arithmetic reference model.
module tb_pipe_exe_md;

    localparam int OP_MULT  = 0;
    localparam int OP_MULTU = 1;
    localparam int OP_DIV   = 2;
    localparam int OP_DIVU  = 3;
    localparam int OP_MTHI  = 4;
    localparam int OP_MTLO  = 5;
    localparam int OP_MFHI  = 6;
    localparam int OP_MFLO  = 7;
    localparam int OP_NOP   = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        mult = 1'b0, multu = 1'b0, div = 1'b0, divu = 1'b0;
    logic        mthi = 1'b0, mtlo = 1'b0, mfhi = 1'b0, mflo = 1'b0;
    logic        flush = 1'b0;
    logic        stall, busy;
    logic [31:0] hilo_rdata, hi, lo;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] m_hi  = '0;
    logic [31:0] m_lo  = '0;

    pipe_exe_md dut (
        .clk        (clk),
        .rst        (rst),
        .a          (a),
        .b          (b),
        .mult       (mult),
        .multu      (multu),
        .div        (div),
        .divu       (divu),
        .mthi       (mthi),
        .mtlo       (mtlo),
        .mfhi       (mfhi),
        .mflo       (mflo),
        .flush      (flush),
        .stall      (stall),
        .busy       (busy),
        .hilo_rdata (hilo_rdata),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_strobes(input int op);
        mult  = (op == OP_MULT);
        multu = (op == OP_MULTU);
        div   = (op == OP_DIV);
        divu  = (op == OP_DIVU);
        mthi  = (op == OP_MTHI);
        mtlo  = (op == OP_MTLO);
        mfhi  = (op == OP_MFHI);
        mflo  = (op == OP_MFLO);
    endtask

    function automatic int exp_stalls(input int op);
        if (op == OP_MULT || op == OP_MULTU) return 2;
        if (op == OP_DIV || op == OP_DIVU) return 33;
        return 0;
    endfunction

    // Architectural effect of one completed instruction
    task automatic model(input int op, input logic [31:0] av, input logic [31:0] bv);
        longint sa, sb;
        logic [63:0] p;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        case (op)
            OP_MULT: begin
                p = 64'(sa * sb);
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            OP_MULTU: begin
                p = {32'b0, av} * {32'b0, bv};
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            OP_DIV, OP_DIVU: begin
                if (bv == 32'd0) begin
                    m_lo = 32'hFFFF_FFFF;
                    m_hi = av;
                end else if (op == OP_DIV) begin
                    m_lo = 32'(sa / sb);
                    m_hi = 32'(sa % sb);
                end else begin
                    m_lo = av / bv;
                    m_hi = av % bv;
                end
            end
            OP_MTHI: m_hi = av;
            OP_MTLO: m_lo = av;
            default: ;
        endcase
    endtask

    // Hold the instruction in EX until stall releases it, optionally flushing on cycle flush_at
    task automatic run_instr(input string tag, input int op, input logic [31:0] av,
                             input logic [31:0] bv, input int flush_at);
        int cyc = 0;
        int stalls = 0;
        bit left = 0;
        bit flushed;
        int want;
        logic [31:0] rd = '0;
        logic [31:0] rd_exp;
        rd_exp = (op == OP_MFHI) ? m_hi : m_lo;
        want = exp_stalls(op);
        a = av;
        b = bv;
        set_strobes(op);
        while (!left && cyc < 60) begin
            flush = (cyc == flush_at);
            @(negedge clk);
            if (cyc == 0) rd = hilo_rdata;
            if (stall) stalls++;
            else left = 1;
            @(posedge clk);
            #1;
            cyc++;
        end
        set_strobes(OP_NOP);
        flush = 1'b0;
        check({tag, "_released"}, 32'(left), 32'd1);
        flushed = (flush_at == 0) || (flush_at > 0 && flush_at < want);
        if (flushed) want = flush_at;
        else model(op, av, bv);
        check({tag, "_stalls"}, 32'(stalls), 32'(want));
        check({tag, "_hi"}, hi, m_hi);
        check({tag, "_lo"}, lo, m_lo);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        if (op == OP_MFHI || op == OP_MFLO) check({tag, "_rdata"}, rd, rd_exp);
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        // Reset state
        set_strobes(OP_NOP);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Multiply
        run_instr("mult_neg3x5", OP_MULT, 32'hFFFF_FFFD, 32'd5, -1);
        check("mult_hi_const", hi, 32'hFFFF_FFFF);
        check("mult_lo_const", lo, 32'hFFFF_FFF1);
        run_instr("multu_max_x2", OP_MULTU, 32'hFFFF_FFFF, 32'd2, -1);
        check("multu_hi_const", hi, 32'h0000_0001);
        check("multu_lo_const", lo, 32'hFFFF_FFFE);

        // Divide
        run_instr("divu_100_7", OP_DIVU, 32'd100, 32'd7, -1);
        check("divu_lo_const", lo, 32'h0000_000E);
        check("divu_hi_const", hi, 32'h0000_0002);
        run_instr("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, -1);
        check("div_lo_const", lo, 32'hFFFF_FFFD);
        check("div_hi_const", hi, 32'hFFFF_FFFF);
        run_instr("div_by_zero", OP_DIV, 32'h0000_1234, 32'd0, -1);
        check("div0_lo_const", lo, 32'hFFFF_FFFF);
        check("div0_hi_const", hi, 32'h0000_1234);
        run_instr("divu_by_zero", OP_DIVU, 32'h8000_0001, 32'd0, -1);
        run_instr("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        check("div_min_lo_const", lo, 32'h8000_0000);
        check("div_min_hi_const", hi, 32'h0000_0000);

        // Moves and reads
        run_instr("mthi", OP_MTHI, 32'hA5A5_A5A5, 32'd0, -1);
        run_instr("mfhi", OP_MFHI, 32'd0, 32'd0, -1);
        run_instr("mtlo", OP_MTLO, 32'h1357_9BDF, 32'd0, -1);
        run_instr("mflo", OP_MFLO, 32'd0, 32'd0, -1);

        // Flushes: mid-divide, mid-multiply, and on an IDLE move
        run_instr("div_flush10", OP_DIV, 32'd1000, 32'd3, 10);
        run_instr("mult_flush1", OP_MULT, 32'd7, 32'd9, 1);
        run_instr("mthi_flush0", OP_MTHI, 32'hDEAD_BEEF, 32'd0, 0);

        // Synchronous reset in the middle of a divide
        a = 32'd500;
        b = 32'd9;
        set_strobes(OP_DIVU);
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        check("rstdiv_busy_before", 32'(busy), 32'd1);
        rst = 1'b0;
        set_strobes(OP_NOP);
        @(posedge clk);
        #1;
        rst = 1'b1;
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        check("rstdiv_busy", 32'(busy), 32'd0);
        check("rstdiv_stall", 32'(stall), 32'd0);
        check("rstdiv_hi", hi, 32'd0);
        check("rstdiv_lo", lo, 32'd0);

        // Reset glitch between edges must not disturb state
        @(posedge clk);
        #1;
        run_instr("mthi_pre_glitch", OP_MTHI, 32'h0F0F_1234, 32'd0, -1);
        @(negedge clk);
        rst = 1'b0;
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("glitch_hi", hi, 32'h0F0F_1234);
        check("glitch_busy", 32'(busy), 32'd0);

        // Randomized instruction stream
        for (int i = 0; i < 40; i++) begin
            int op;
            int fa;
            op = int'($urandom_range(0, 7));
            fa = -1;
            if (exp_stalls(op) > 0 && $urandom_range(0, 4) == 0)
                fa = int'($urandom_range(0, 32'(exp_stalls(op) - 1)));
            run_instr($sformatf("rnd%0d_op%0d", i, op), op, rnd_val(), rnd_val(), fa);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
